mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Word-granular backing-memory responder: the target end of the cache's external
//  memory port (ready/addr/ren/wen/wdata -> rdata/valid). Accepts at most one request
//  per cycle, completes writes at acceptance, returns reads in order after a fixed
//  pipelined latency. Serves as the main-memory model behind icache/dcache.
// PARAMETERS
//  ADDR_W     12  word-address bits; array holds 2**ADDR_W 32-bit words
//  LATENCY     4  cycles from read acceptance edge to o_mem_valid; legal range 1..16
//  MAX_OUT     4  max reads in flight (accepted, not yet returned); legal range 1..16
// PORTS
//  i_clk           in   1   clock
//  i_rst           in   1   reset, synchronous, active-high
//  i_stall         in   1   bench backpressure: forces o_mem_ready low
//  o_mem_ready     out  1   request will be accepted on this edge if ren^wen
//  i_mem_addr      in   32  byte address; [1:0] ignored; word index = [ADDR_W+1:2]
//  i_mem_ren       in   1   read request
//  i_mem_wen       in   1   write request (full word, no mask)
//  i_mem_wdata     in   32  write data
//  o_mem_rdata     out  32  read data, meaningful only while o_mem_valid
//  o_mem_valid     out  1   one-cycle pulse per returned read
//  o_protocol_err  out  1   sticky: ren&&wen seen while o_mem_ready
// BEHAVIOUR
//  Reset: o_mem_valid=0, o_mem_rdata=0, o_protocol_err=0, in-flight count=0, all
//   pipeline stage valids cleared. Array contents NOT cleared (zero at time 0).
//  Reset mid-operation: all in-flight reads discarded; no valid pulse for them after
//   reset deasserts. Writes accepted before the reset edge persist.
//  o_mem_ready = ~i_stall && (count < MAX_OUT); combinational from regs + i_stall only.
//  Accept at edge k iff o_mem_ready && (i_mem_ren ^ i_mem_wen). Otherwise no effect.
//  Request with o_mem_ready low: silently dropped (requester must resample ready).
//  ren&&wen with ready high: neither performed; o_protocol_err set until reset.
//  Write accepted at edge k: array[idx] <= wdata at edge k. Does not touch count.
//  Read accepted at edge k: array[idx] sampled at edge k (sees writes accepted at
//   edges < k) into a LATENCY-stage shift pipeline; o_mem_valid high and o_mem_rdata
//   = that word during the cycle after edge k+LATENCY-1 (LATENCY=1: cycle after k).
//  Reads return strictly in acceptance order; back-to-back reads -> back-to-back valids.
//  count: +1 on read accept, -1 on valid pulse; both same cycle -> unchanged. count
//   never exceeds MAX_OUT and never underflows.
//  i_stall only gates acceptance; in-flight reads keep advancing and retire.
//  Address aliasing: bits above ADDR_W+1 ignored (0x0000_0010 and 0x0000_4010 alias
//   with ADDR_W=12).
//  o_mem_rdata holds last returned word when o_mem_valid low (0 after reset).
// TESTING
//  1. Reset, write 0xDEADBEEF @0x40, then read @0x40 next cycle -> valid exactly 4
//     cycles after read accept, rdata=0xDEADBEEF, count back to 0.
//  2. LATENCY=4, MAX_OUT=4: 4 reads @0x100,0x104,0x108,0x10C on consecutive cycles
//     (preloaded 1,2,3,4) -> ready drops after 4th accept, 4 consecutive valids 1,2,3,4
//     in order, ready returns the cycle after the first valid.
//  3. i_stall high 3 cycles with 2 reads in flight -> ready=0, both valids still arrive
//     on schedule; a request held during stall is not performed.
//  4. ren=wen=1 with ready high -> no array change, no valid, o_protocol_err=1 and stays
//     1 until i_rst.
//  5. 3 reads in flight, assert i_rst one cycle -> no o_mem_valid afterwards, ready=1,
//     o_protocol_err=0, earlier written data still readable.
//  6. LATENCY=1, MAX_OUT=1: read every cycle -> accepts every other cycle at most; each
//     valid pulse lands the cycle after its accept; write then read same addr on
//     consecutive edges returns new data.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between a cache's external memory port and its backing memory.
// The requester uses the master modport; the memory model uses the slave modport.
interface mem_responder_if;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  modport master (
    input  mem_ready, mem_rdata, mem_valid,
    output mem_addr, mem_ren, mem_wen, mem_wdata
  );

  modport slave (
    output mem_ready, mem_rdata, mem_valid,
    input  mem_addr, mem_ren, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mem_responder.sv
// Word-granular backing memory: writes complete at acceptance, reads return in order
// after a fixed pipelined latency, with at most MAX_OUT reads in flight.
module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 4,
  parameter int MAX_OUT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  mem_responder_if.slave  bus,
  output logic            o_protocol_err
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] idx;
  logic              ready;
  logic              rd_accept;
  logic              wr_accept;
  logic              both_req;
  logic              unused_addr_bits;

  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              protocol_err_reg;
  logic [LATENCY-1:0] valid_pipe_reg;
  logic [31:0]       data_pipe_reg [0:LATENCY-1];

  // Byte lane and bits above the array size alias onto the same word.
  assign idx              = bus.mem_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  assign ready     = ~i_stall && (count_reg < CNT_W'(MAX_OUT));
  assign rd_accept = ~i_rst && ready && bus.mem_ren && ~bus.mem_wen;
  assign wr_accept = ~i_rst && ready && bus.mem_wen && ~bus.mem_ren;
  assign both_req  = ~i_rst && ready && bus.mem_ren && bus.mem_wen;

  assign bus.mem_ready  = ready;
  assign bus.mem_valid  = valid_pipe_reg[LATENCY-1];
  assign bus.mem_rdata  = data_pipe_reg[LATENCY-1];
  assign o_protocol_err = protocol_err_reg;

  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem[idx] <= bus.mem_wdata;
    end
  end

  // Each stage only loads when its upstream stage is valid, so the last stage
  // keeps the most recently returned word while no read is retiring.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_pipe_reg <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_pipe_reg[i] <= '0;
      end
    end else begin
      valid_pipe_reg[0] <= rd_accept;
      if (rd_accept) begin
        data_pipe_reg[0] <= mem[idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
        if (valid_pipe_reg[i-1]) begin
          data_pipe_reg[i] <= data_pipe_reg[i-1];
        end
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({rd_accept, valid_pipe_reg[LATENCY-1]})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg        <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (both_req) begin
        protocol_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: two instances (latency 4 / 4 outstanding and
// latency 1 / 1 outstanding) checked against a queue-based reference model.
module tb_mem_responder;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic clk;
  logic rst;
  logic stall_a, stall_b;
  logic err_a, err_b;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.ADDR_W(12), .LATENCY(4), .MAX_OUT(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_stall(stall_a), .bus(bus_a), .o_protocol_err(err_a)
  );

  mem_responder #(.ADDR_W(12), .LATENCY(1), .MAX_OUT(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_stall(stall_b), .bus(bus_b), .o_protocol_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          sel     = 0;
  int          cyc     = 0;
  int          lat  [0:1];
  int          maxo [0:1];
  rd_t         exp_q[$];
  logic [31:0] ref_mem [0:1][0:4095];
  logic [31:0] last_rd [0:1];
  logic        err_m   [0:1];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", tag, sel, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic stall);
    bus_a.mem_ren = 1'b0; bus_a.mem_wen = 1'b0; bus_a.mem_addr = '0; bus_a.mem_wdata = '0;
    bus_b.mem_ren = 1'b0; bus_b.mem_wen = 1'b0; bus_b.mem_addr = '0; bus_b.mem_wdata = '0;
    stall_a = 1'b0; stall_b = 1'b0;
    if (sel == 0) begin
      bus_a.mem_ren = ren; bus_a.mem_wen = wen; bus_a.mem_addr = addr;
      bus_a.mem_wdata = wdata; stall_a = stall;
    end else begin
      bus_b.mem_ren = ren; bus_b.mem_wen = wen; bus_b.mem_addr = addr;
      bus_b.mem_wdata = wdata; stall_b = stall;
    end
  endtask

  // One clock cycle: drive, check outputs at the falling edge, then advance the model.
  task automatic step(input logic ren, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic stall);
    logic        exp_ready, exp_valid;
    logic        obs_ready, obs_valid, obs_err;
    logic [31:0] obs_rdata;
    rd_t         e;
    drive(ren, wen, addr, wdata, stall);
    @(negedge clk);
    obs_ready = (sel == 0) ? bus_a.mem_ready : bus_b.mem_ready;
    obs_valid = (sel == 0) ? bus_a.mem_valid : bus_b.mem_valid;
    obs_rdata = (sel == 0) ? bus_a.mem_rdata : bus_b.mem_rdata;
    obs_err   = (sel == 0) ? err_a : err_b;
    exp_ready = !stall && (exp_q.size() < maxo[sel]);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (exp_valid) begin
      last_rd[sel] = exp_q[0].data;
      $display("[TB] dut%0d cyc %0d RET data %h", sel, cyc, exp_q[0].data);
    end
    check("ready", 32'(obs_ready), 32'(exp_ready));
    check("valid", 32'(obs_valid), 32'(exp_valid));
    check("rdata", obs_rdata, last_rd[sel]);
    check("perr", 32'(obs_err), 32'(err_m[sel]));
    if (exp_valid) void'(exp_q.pop_front());
    if (exp_ready && ren && wen) begin
      err_m[sel] = 1'b1;
      $display("[TB] dut%0d cyc %0d BOTH addr %h (ignored)", sel, cyc, addr);
    end else if (exp_ready && wen) begin
      ref_mem[sel][widx(addr)] = wdata;
      $display("[TB] dut%0d cyc %0d WR addr %h data %h", sel, cyc, addr, wdata);
    end else if (exp_ready && ren) begin
      e.due  = cyc + lat[sel];
      e.data = ref_mem[sel][widx(addr)];
      exp_q.push_back(e);
      $display("[TB] dut%0d cyc %0d RD addr %h", sel, cyc, addr);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      err_m[d]   = 1'b0;
      last_rd[d] = 32'h0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_C000) | ((32'h200 + $urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
    return a;
  endfunction

  task automatic preload_random_set();
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, (32'h200 + i) << 2, $urandom, 1'b0);
  endtask

  task automatic random_phase(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 1'b1, rand_addr(), $urandom, 1'b0);
      else if (r < 45) step(1'b1, 1'b0, rand_addr(), $urandom, $urandom_range(0, 4) == 0);
      else if (r < 75) step(1'b0, 1'b1, rand_addr(), $urandom, $urandom_range(0, 4) == 0);
      else             step(1'b0, 1'b0, 32'h0, 32'h0, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    lat[0] = 4; maxo[0] = 4;
    lat[1] = 1; maxo[1] = 1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Basic write then read.
    sel = 0;
    idle(1);
    step(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
    step(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    idle(6);

    // Fill the outstanding window, keep requesting while ready is low.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h100 + 4 * i, 32'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h100 + 4 * i, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h104, 32'h0, 1'b0);
    idle(6);

    // Stall with reads in flight; a write held during stall must not land.
    step(1'b1, 1'b0, 32'h108, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h10C, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h100, 32'h55, 1'b1);
    step(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    idle(6);

    // Simultaneous read and write: ignored, sticky error.
    step(1'b1, 1'b1, 32'h104, 32'h77, 1'b0);
    step(1'b1, 1'b0, 32'h104, 32'h0, 1'b0);
    idle(6);

    // Address aliasing above the array size.
    step(1'b0, 1'b1, 32'h0000_4010, 32'hA11A_5ED0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_0012, 32'h0, 1'b0);
    idle(6);

    // Reset with reads in flight; earlier writes survive.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h100 + 4 * i, 32'h0, 1'b0);
    do_reset();
    idle(6);
    step(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    idle(6);

    preload_random_set();
    random_phase(250);
    idle(8);

    // Single-cycle latency, one outstanding read.
    sel = 1;
    idle(2);
    step(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1'b0);
    step(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    preload_random_set();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, rand_addr(), 32'h0, 1'b0);
    random_phase(150);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
